geri_yaz: RTL and testbench

Writeback collector between the execution units and the register-read stage's writeback port. Each source (ALU, memory, multiplier) deposits completed results into a private 2-entry FIFO under a gecerli/hazir handshake. A round-robin arbiter drains at most one entry per cycle into a registered writeback bus that drives `geriyaz_veri/adres/etiket/gecerli` of the register-read stage.

---
 rtl/geri_yaz_pkg.sv | 30 +++
 rtl/geri_yaz_fifo.sv | 64 ++++++
 rtl/geri_yaz.sv | 112 +++++++++++
 tb/tb_geri_yaz.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/geri_yaz_pkg.sv
// Shared definitions for the writeback collector.
//   VERI_BIT / YAZMAC_BIT / UOP_TAG_BIT : payload field widths
//   LOW / HIGH                           : logic level constants
//   GY_KAYNAK_*                          : source index assignment
//   gy_kayit_t                           : one buffered writeback entry
//   sarmal_arti                          : increment modulo n
package geri_yaz_pkg;

  localparam int unsigned VERI_BIT    = 32;
  localparam int unsigned YAZMAC_BIT  = 5;
  localparam int unsigned UOP_TAG_BIT = 6;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  localparam int unsigned GY_KAYNAK_ALU    = 0;
  localparam int unsigned GY_KAYNAK_BELLEK = 1;
  localparam int unsigned GY_KAYNAK_CARPMA = 2;

  typedef struct packed {
    logic [VERI_BIT-1:0]    veri;
    logic [YAZMAC_BIT-1:0]  adres;
    logic [UOP_TAG_BIT-1:0] etiket;
  } gy_kayit_t;

  function automatic int unsigned sarmal_arti(input int unsigned x, input int unsigned n);
    return (x + 1 >= n) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/geri_yaz_fifo.sv
// Small synchronous FIFO with an occupancy counter.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   push, din     : write request and data (ignored while full)
//   pop           : read request (ignored while empty)
//   full, empty   : decoded from the registered count only
//   head          : oldest entry
module geri_yaz_fifo #(
  parameter int unsigned GENISLIK = 8,
  parameter int unsigned DERINLIK = 2
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                push,
  input  logic                pop,
  input  logic [GENISLIK-1:0] din,
  output logic                full,
  output logic                empty,
  output logic [GENISLIK-1:0] head
);

  localparam int unsigned PTR_BIT = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int unsigned SAY_BIT = $clog2(DERINLIK + 1);

  logic [GENISLIK-1:0] mem [DERINLIK];
  logic [PTR_BIT-1:0]  yaz_ptr;
  logic [PTR_BIT-1:0]  oku_ptr;
  logic [SAY_BIT-1:0]  sayac;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (sayac == SAY_BIT'(DERINLIK));
  assign empty   = (sayac == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[oku_ptr];

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[yaz_ptr] <= din;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
    end else begin
      if (push_ok) begin
        yaz_ptr <= yaz_ptr + PTR_BIT'(1);
      end
      if (pop_ok) begin
        oku_ptr <= oku_ptr + PTR_BIT'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   sayac <= sayac + SAY_BIT'(1);
        2'b01:   sayac <= sayac - SAY_BIT'(1);
        default: sayac <= sayac;
      endcase
    end
  end

endmodule

// File: rtl/geri_yaz.sv
// Writeback collector: per-source FIFOs drained round-robin into a
// registered writeback bus, at most one entry per cycle.
//   clk_i, rstn_i         : clock, asynchronous active-low reset
//   sonuc_*_i             : per-source result payload/valid, source 0 at LSBs
//   sonuc_hazir_o         : per-source ready (FIFO not full)
//   geriyaz_*_o           : registered writeback bus
//   bos_o                 : nothing buffered and no writeback in flight
module geri_yaz
  import geri_yaz_pkg::*;
#(
  parameter int unsigned KAYNAK_SAYISI = 3,
  parameter int unsigned FIFO_DERINLIK = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [KAYNAK_SAYISI*VERI_BIT-1:0]    sonuc_veri_i,
  input  logic [KAYNAK_SAYISI*YAZMAC_BIT-1:0]  sonuc_adres_i,
  input  logic [KAYNAK_SAYISI*UOP_TAG_BIT-1:0] sonuc_etiket_i,
  input  logic [KAYNAK_SAYISI-1:0]             sonuc_gecerli_i,
  output logic [KAYNAK_SAYISI-1:0]             sonuc_hazir_o,
  output logic [VERI_BIT-1:0]                  geriyaz_veri_o,
  output logic [YAZMAC_BIT-1:0]                geriyaz_adres_o,
  output logic [UOP_TAG_BIT-1:0]               geriyaz_etiket_o,
  output logic                                 geriyaz_gecerli_o,
  output logic                                 bos_o
);

  localparam int unsigned SEC_BIT = (KAYNAK_SAYISI > 1) ? $clog2(KAYNAK_SAYISI) : 1;

  logic [KAYNAK_SAYISI-1:0]   dolu;
  logic [KAYNAK_SAYISI-1:0]   bos_fifo;
  logic [KAYNAK_SAYISI-1:0]   cekme;
  gy_kayit_t                  bas [KAYNAK_SAYISI];

  logic [SEC_BIT-1:0]         son_secilen;
  logic [2*KAYNAK_SAYISI-1:0] donmus;
  int unsigned                baslangic;
  int unsigned                ofs;
  int unsigned                secilen;
  logic                       verildi;
  gy_kayit_t                  secili;

  for (genvar g = 0; g < KAYNAK_SAYISI; g++) begin : g_kaynak
    geri_yaz_fifo #(
      .GENISLIK ($bits(gy_kayit_t)),
      .DERINLIK (FIFO_DERINLIK)
    ) u_fifo (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .push   (sonuc_gecerli_i[g]),
      .pop    (cekme[g]),
      .din    ({sonuc_veri_i[g*VERI_BIT +: VERI_BIT],
                sonuc_adres_i[g*YAZMAC_BIT +: YAZMAC_BIT],
                sonuc_etiket_i[g*UOP_TAG_BIT +: UOP_TAG_BIT]}),
      .full   (dolu[g]),
      .empty  (bos_fifo[g]),
      .head   (bas[g])
    );
  end

  assign sonuc_hazir_o = ~dolu;
  assign bos_o         = (&bos_fifo) && !geriyaz_gecerli_o;

  // Round-robin: rotate the request vector so the source after the last
  // winner sits at bit 0, take the lowest set bit, then map it back.
  always_comb begin
    baslangic = sarmal_arti(32'(son_secilen), KAYNAK_SAYISI);
    donmus    = {~bos_fifo, ~bos_fifo} >> baslangic;
    verildi   = LOW;
    ofs       = 0;
    for (int unsigned i = 0; i < KAYNAK_SAYISI; i++) begin
      if (!verildi && donmus[i]) begin
        verildi = HIGH;
        ofs     = i;
      end
    end
    secilen = baslangic + ofs;
    if (secilen >= KAYNAK_SAYISI) begin
      secilen = secilen - KAYNAK_SAYISI;
    end
    cekme  = '0;
    secili = '0;
    for (int unsigned i = 0; i < KAYNAK_SAYISI; i++) begin
      if (verildi && (secilen == i)) begin
        cekme[i] = HIGH;
        secili   = bas[i];
      end
    end
  end

  // An x0 destination still takes its slot and loads the payload,
  // but is never presented as a valid writeback.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      son_secilen       <= SEC_BIT'(KAYNAK_SAYISI - 1);
      geriyaz_veri_o    <= '0;
      geriyaz_adres_o   <= '0;
      geriyaz_etiket_o  <= '0;
      geriyaz_gecerli_o <= LOW;
    end else begin
      geriyaz_gecerli_o <= LOW;
      if (verildi) begin
        son_secilen       <= SEC_BIT'(secilen);
        geriyaz_veri_o    <= secili.veri;
        geriyaz_adres_o   <= secili.adres;
        geriyaz_etiket_o  <= secili.etiket;
        geriyaz_gecerli_o <= (secili.adres != '0);
      end
    end
  end

endmodule

// File: tb/tb_geri_yaz.sv
// Self-checking bench for geri_yaz: per-source scoreboard queues filled on
// accepted pushes, drained and compared as writebacks appear.
module tb_geri_yaz;
  import geri_yaz_pkg::*;

  localparam int N = 3;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;

  logic [VERI_BIT-1:0]    s_veri   [N];
  logic [YAZMAC_BIT-1:0]  s_adres  [N];
  logic [UOP_TAG_BIT-1:0] s_etiket [N];
  logic [N-1:0]           s_gecerli;

  logic [N*VERI_BIT-1:0]    sonuc_veri_i;
  logic [N*YAZMAC_BIT-1:0]  sonuc_adres_i;
  logic [N*UOP_TAG_BIT-1:0] sonuc_etiket_i;
  logic [N-1:0]             sonuc_hazir_o;
  logic [VERI_BIT-1:0]      geriyaz_veri_o;
  logic [YAZMAC_BIT-1:0]    geriyaz_adres_o;
  logic [UOP_TAG_BIT-1:0]   geriyaz_etiket_o;
  logic                     geriyaz_gecerli_o;
  logic                     bos_o;

  assign sonuc_veri_i   = {s_veri[2], s_veri[1], s_veri[0]};
  assign sonuc_adres_i  = {s_adres[2], s_adres[1], s_adres[0]};
  assign sonuc_etiket_i = {s_etiket[2], s_etiket[1], s_etiket[0]};

  geri_yaz #(
    .KAYNAK_SAYISI (N),
    .FIFO_DERINLIK (2)
  ) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .sonuc_veri_i      (sonuc_veri_i),
    .sonuc_adres_i     (sonuc_adres_i),
    .sonuc_etiket_i    (sonuc_etiket_i),
    .sonuc_gecerli_i   (s_gecerli),
    .sonuc_hazir_o     (sonuc_hazir_o),
    .geriyaz_veri_o    (geriyaz_veri_o),
    .geriyaz_adres_o   (geriyaz_adres_o),
    .geriyaz_etiket_o  (geriyaz_etiket_o),
    .geriyaz_gecerli_o (geriyaz_gecerli_o),
    .bos_o             (bos_o)
  );

  always #5 clk_i = ~clk_i;

  int        chk = 0;
  int        fail = 0;
  int        out_cnt = 0;
  int        cyc = 0;
  bit        mon_en = 1'b0;
  gy_kayit_t bekl_q [N][$];
  int        src_log[$];
  int        cyc_log[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Outputs from the previous edge are checked first, then the pushes that
  // the coming edge will accept are recorded (inputs only move after posedge).
  always @(negedge clk_i) begin
    gy_kayit_t g;
    bit        bulundu;
    if (mon_en) begin
      if (geriyaz_gecerli_o === 1'b1) begin
        g       = '{geriyaz_veri_o, geriyaz_adres_o, geriyaz_etiket_o};
        bulundu = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!bulundu && bekl_q[i].size() > 0 && bekl_q[i][0] == g) begin
            bulundu = 1'b1;
            void'(bekl_q[i].pop_front());
            src_log.push_back(i);
            cyc_log.push_back(cyc);
          end
        end
        chk++;
        out_cnt++;
        if (!bulundu) begin
          fail++;
          $display("FAIL wb_match got veri=%h adres=%0d etiket=%h, required the head of a source queue",
                   geriyaz_veri_o, geriyaz_adres_o, geriyaz_etiket_o);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (s_gecerli[i] && sonuc_hazir_o[i] && s_adres[i] != '0)
          bekl_q[i].push_back('{s_veri[i], s_adres[i], s_etiket[i]});
      end
    end
  end

  // Called and returning at posedge+1; holds the payload until accepted.
  task automatic gonder(input int src, input logic [VERI_BIT-1:0] v,
                        input logic [YAZMAC_BIT-1:0] a, input logic [UOP_TAG_BIT-1:0] t);
    bit ok = 1'b0;
    s_veri[src]    = v;
    s_adres[src]   = a;
    s_etiket[src]  = t;
    s_gecerli[src] = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk_i);
      ok = sonuc_hazir_o[src];
      @(posedge clk_i);
      #1;
    end
    s_gecerli[src] = 1'b0;
    chk++;
    if (!ok) begin
      fail++;
      $display("FAIL push_timeout src=%0d accepted=0 required=1", src);
    end
  endtask

  task automatic bosalt();
    bit bitti = 1'b0;
    for (int k = 0; k < 40 && !bitti; k++) begin
      @(negedge clk_i);
      #1;
      bitti = bos_o && bekl_q[0].size() == 0 && bekl_q[1].size() == 0 && bekl_q[2].size() == 0;
    end
    chk++;
    if (!bitti) begin
      fail++;
      $display("FAIL drain bos_o=%b pending=%0d/%0d/%0d required bos_o=1 pending=0/0/0",
               bos_o, bekl_q[0].size(), bekl_q[1].size(), bekl_q[2].size());
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_uygula();
    mon_en    = 1'b0;
    s_gecerli = '0;
    rstn_i    = 1'b0;
    for (int i = 0; i < N; i++) bekl_q[i].delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    chk++;
    if (geriyaz_gecerli_o !== 1'b0 || geriyaz_veri_o !== '0 || geriyaz_adres_o !== '0 ||
        geriyaz_etiket_o !== '0 || sonuc_hazir_o !== 3'b111 || bos_o !== 1'b1) begin
      fail++;
      $display("FAIL reset_state gecerli=%b veri=%h adres=%0d etiket=%h hazir=%b bos=%b required 0/0/0/0/111/1",
               geriyaz_gecerli_o, geriyaz_veri_o, geriyaz_adres_o, geriyaz_etiket_o, sonuc_hazir_o, bos_o);
    end
    reset_uygula();
    chk++;
    if (sonuc_hazir_o !== 3'b111 || bos_o !== 1'b1 || geriyaz_gecerli_o !== 1'b0) begin
      fail++;
      $display("FAIL post_reset hazir=%b bos=%b gecerli=%b required 111/1/0",
               sonuc_hazir_o, bos_o, geriyaz_gecerli_o);
    end
  endtask

  task automatic test_single();
    gonder(1, 32'hDEADBEEF, 5'd5, 6'd3);
    @(negedge clk_i);
    chk++;
    if (geriyaz_gecerli_o !== 1'b0) begin
      fail++;
      $display("FAIL single_latency gecerli=%b one edge after accept, required 0", geriyaz_gecerli_o);
    end
    @(negedge clk_i);
    chk++;
    if (geriyaz_gecerli_o !== 1'b1 || geriyaz_veri_o !== 32'hDEADBEEF ||
        geriyaz_adres_o !== 5'd5 || geriyaz_etiket_o !== 6'd3) begin
      fail++;
      $display("FAIL single_wb gecerli=%b veri=%h adres=%0d etiket=%0d required 1/deadbeef/5/3",
               geriyaz_gecerli_o, geriyaz_veri_o, geriyaz_adres_o, geriyaz_etiket_o);
    end
    @(negedge clk_i);
    chk++;
    if (geriyaz_gecerli_o !== 1'b0 || bos_o !== 1'b1) begin
      fail++;
      $display("FAIL single_after gecerli=%b bos=%b required 0/1", geriyaz_gecerli_o, bos_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_back_to_back();
    int t0;
    src_log.delete();
    cyc_log.delete();
    t0 = cyc;
    for (int k = 0; k < 6; k++) gonder(0, 32'h1000 + 32'(k), 5'(k + 1), 6'(6'h20 + k));
    chk++;
    if (cyc - t0 != 6) begin
      fail++;
      $display("FAIL stream_push cycles=%0d required 6", cyc - t0);
    end
    bosalt();
    chk++;
    if (cyc_log.size() != 6 || cyc_log[cyc_log.size() - 1] - cyc_log[0] != 5) begin
      fail++;
      $display("FAIL stream_out count=%0d required 6 on consecutive cycles", cyc_log.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    reset_uygula();
    src_log.delete();
    cyc_log.delete();
    fork
      begin gonder(0, 32'hA0, 5'd10, 6'h01); gonder(0, 32'hA1, 5'd11, 6'h02); end
      begin gonder(1, 32'hB0, 5'd12, 6'h03); gonder(1, 32'hB1, 5'd13, 6'h04); end
      begin gonder(2, 32'hC0, 5'd14, 6'h05); gonder(2, 32'hC1, 5'd15, 6'h06); end
    join
    bosalt();
    ok = (src_log.size() == 6);
    for (int k = 0; k < 6 && ok; k++) if (src_log[k] != k % 3) ok = 1'b0;
    chk++;
    if (!ok) begin
      fail++;
      $display("FAIL rr_order got=%p required 0,1,2,0,1,2", src_log);
    end
    chk++;
    if (cyc_log.size() != 6 || cyc_log[5] - cyc_log[0] != 5) begin
      fail++;
      $display("FAIL rr_consecutive count=%0d required 6 on consecutive cycles", cyc_log.size());
    end
  endtask

  task automatic test_full();
    int o0;
    bit dolu_goruldu = 1'b0;
    o0 = out_cnt;
    fork
      for (int k = 0; k < 6; k++) gonder(0, 32'h5000 + 32'(k), 5'(k + 1), 6'(k));
      for (int k = 0; k < 6; k++) gonder(1, 32'h6000 + 32'(k), 5'(k + 8), 6'(k + 16));
      for (int k = 0; k < 4; k++) gonder(2, 32'h7000 + 32'(k), 5'(k + 20), 6'(k + 32));
      repeat (12) begin
        @(negedge clk_i);
        if (sonuc_hazir_o[2] === 1'b0) dolu_goruldu = 1'b1;
      end
    join
    chk++;
    if (!dolu_goruldu) begin
      fail++;
      $display("FAIL full_hazir hazir2_low_seen=0 required 1");
    end
    bosalt();
    chk++;
    if (out_cnt - o0 != 16) begin
      fail++;
      $display("FAIL full_count writebacks=%0d required 16", out_cnt - o0);
    end
    chk++;
    if (sonuc_hazir_o !== 3'b111) begin
      fail++;
      $display("FAIL full_hazir_after hazir=%b required 111", sonuc_hazir_o);
    end
  endtask

  task automatic test_x0();
    gonder(0, 32'h0BAD0000, 5'd0, 6'h15);
    gonder(0, 32'h00000777, 5'd7, 6'h16);
    @(negedge clk_i);
    chk++;
    if (geriyaz_gecerli_o !== 1'b0 || geriyaz_adres_o !== 5'd0 ||
        geriyaz_etiket_o !== 6'h15 || geriyaz_veri_o !== 32'h0BAD0000) begin
      fail++;
      $display("FAIL x0_slot gecerli=%b adres=%0d etiket=%h veri=%h required 0/0/15/0bad0000",
               geriyaz_gecerli_o, geriyaz_adres_o, geriyaz_etiket_o, geriyaz_veri_o);
    end
    @(negedge clk_i);
    chk++;
    if (geriyaz_gecerli_o !== 1'b1 || geriyaz_adres_o !== 5'd7 || geriyaz_etiket_o !== 6'h16) begin
      fail++;
      $display("FAIL x0_next gecerli=%b adres=%0d etiket=%h required 1/7/16",
               geriyaz_gecerli_o, geriyaz_adres_o, geriyaz_etiket_o);
    end
    @(posedge clk_i);
    #1;
    bosalt();
  endtask

  task automatic test_async_reset();
    fork
      begin gonder(0, 32'hE0, 5'd1, 6'h31); gonder(0, 32'hE1, 5'd2, 6'h32); end
      begin gonder(1, 32'hE2, 5'd3, 6'h33); gonder(1, 32'hE3, 5'd4, 6'h34); end
      begin gonder(2, 32'hE4, 5'd5, 6'h35); gonder(2, 32'hE5, 5'd6, 6'h36); end
    join
    chk++;
    if (geriyaz_gecerli_o !== 1'b1) begin
      fail++;
      $display("FAIL areset_pre gecerli=%b required 1", geriyaz_gecerli_o);
    end
    #2;
    mon_en = 1'b0;
    rstn_i = 1'b0;
    #1;
    chk++;
    if (geriyaz_gecerli_o !== 1'b0 || sonuc_hazir_o !== 3'b111 || bos_o !== 1'b1 || geriyaz_veri_o !== '0) begin
      fail++;
      $display("FAIL areset_immediate gecerli=%b hazir=%b bos=%b veri=%h required 0/111/1/0",
               geriyaz_gecerli_o, sonuc_hazir_o, bos_o, geriyaz_veri_o);
    end
    for (int i = 0; i < N; i++) bekl_q[i].delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk++;
      if (geriyaz_gecerli_o !== 1'b0 || sonuc_hazir_o !== 3'b111 || bos_o !== 1'b1) begin
        fail++;
        $display("FAIL areset_after cycle=%0d gecerli=%b hazir=%b bos=%b required 0/111/1",
                 k, geriyaz_gecerli_o, sonuc_hazir_o, bos_o);
      end
    end
    mon_en = 1'b1;
  endtask

  initial begin
    s_gecerli = '0;
    for (int i = 0; i < N; i++) begin
      s_veri[i]   = '0;
      s_adres[i]  = '0;
      s_etiket[i] = '0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_full();
    test_x0();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
    $finish;
  end

endmodule
